// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag controller.
// Arbitrates lookups and refill tag writes onto the tag RAM ports,
// returns one-cycle-latency lookup responses, keeps saturating hit/miss
// statistics, and runs a maintenance sequence (drain, clear, acknowledge)
// for invalidate-all and invalidate-line requests.
module dcache_tag_ctrl #(
   parameter int AWT       = 32,
   parameter int WORD_SEL  = 4,
   parameter int ENTRY_SEL = 7
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           lk_valid_i,
   input  logic [AWT-1:0] lk_addr_i,
   output logic           lk_ready_o,
   input  logic           rf_valid_i,
   input  logic [AWT-1:0] rf_addr_i,
   output logic           rf_ready_o,
   input  logic           csr_req_i,
   input  logic           csr_all_i,
   input  logic [AWT-1:0] csr_addr_i,
   output logic           csr_ack_o,
   output logic           tag_rd_en_o,
   output logic [AWT-1:0] tag_rd_addr_o,
   output logic           tag_wr_en_o,
   output logic [AWT-1:0] tag_wr_addr_o,
   output logic           clear_all_o,
   output logic           clear_line_o,
   output logic [AWT-1:0] clear_addr_o,
   input  logic           tag_hit_i,
   output logic           lk_rsp_valid_o,
   output logic           lk_rsp_hit_o,
   output logic [31:0]    hit_cnt_o,
   output logic [31:0]    miss_cnt_o
);

   localparam int ENTRY_LO = WORD_SEL + 2;
   localparam int ENTRY_HI = ENTRY_SEL + WORD_SEL + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           clear_all_q, clear_all_d;
   logic           clear_line_q, clear_line_d;
   logic [AWT-1:0] clear_addr_q, clear_addr_d;
   logic           csr_ack_q, csr_ack_d;
   logic           inflight_q, inflight_d;
   logic [31:0]    hit_cnt_q, hit_cnt_d;
   logic [31:0]    miss_cnt_q, miss_cnt_d;

   logic rf_fire;
   logic lk_fire;
   logic same_entry;
   logic lk_conflict;

   // Handshake arbitration: refills win over a lookup to the same entry,
   // and lookups are held off for the whole maintenance sequence.
   always_comb begin
      same_entry    = (lk_addr_i[ENTRY_HI:ENTRY_LO] == rf_addr_i[ENTRY_HI:ENTRY_LO]);
      rf_ready_o    = (state_q != CLEAR);
      rf_fire       = rf_valid_i && rf_ready_o;
      lk_conflict   = rf_fire && lk_valid_i && same_entry;
      lk_ready_o    = (state_q == IDLE) && !csr_req_i && !lk_conflict;
      lk_fire       = lk_valid_i && lk_ready_o;
      tag_rd_en_o   = lk_fire;
      tag_rd_addr_o = lk_addr_i;
      tag_wr_en_o   = rf_fire;
      tag_wr_addr_o = rf_addr_i;
   end

   // Maintenance FSM next state and its registered strobes.
   always_comb begin
      state_d      = state_q;
      clear_all_d  = 1'b0;
      clear_line_d = 1'b0;
      clear_addr_d = clear_addr_q;
      csr_ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (csr_req_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!lk_fire) begin
               state_d      = CLEAR;
               clear_all_d  = csr_all_i;
               clear_line_d = !csr_all_i;
               clear_addr_d = csr_addr_i;
            end
         end
         CLEAR: begin
            state_d   = DONE;
            csr_ack_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Maintenance FSM state and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         clear_all_q  <= 1'b0;
         clear_line_q <= 1'b0;
         clear_addr_q <= '0;
         csr_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_all_q  <= clear_all_d;
         clear_line_q <= clear_line_d;
         clear_addr_q <= clear_addr_d;
         csr_ack_q    <= csr_ack_d;
      end
   end

   // Response tracking and saturating statistics; invalidate-all wipes
   // the statistics and beats any increment landing in the same cycle.
   always_comb begin
      inflight_d = lk_fire;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (clear_all_q) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (inflight_q) begin
         if (tag_hit_i) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) begin
               hit_cnt_d = hit_cnt_q + 32'd1;
            end
         end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
               miss_cnt_d = miss_cnt_q + 32'd1;
            end
         end
      end
   end

   // In-flight flag and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_q <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Output mapping; the response hit is masked outside response cycles.
   always_comb begin
      csr_ack_o      = csr_ack_q;
      clear_all_o    = clear_all_q;
      clear_line_o   = clear_line_q;
      clear_addr_o   = clear_addr_q;
      lk_rsp_valid_o = inflight_q;
      lk_rsp_hit_o   = inflight_q && tag_hit_i;
      hit_cnt_o      = hit_cnt_q;
      miss_cnt_o     = miss_cnt_q;
   end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed testbench for dcache_tag_ctrl.
// Inputs change 1ns after each rising edge; outputs are sampled 2ns after it.
module tb_dcache_tag_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lk_valid_i;
   logic [31:0] lk_addr_i;
   logic        lk_ready_o;
   logic        rf_valid_i;
   logic [31:0] rf_addr_i;
   logic        rf_ready_o;
   logic        csr_req_i;
   logic        csr_all_i;
   logic [31:0] csr_addr_i;
   logic        csr_ack_o;
   logic        tag_rd_en_o;
   logic [31:0] tag_rd_addr_o;
   logic        tag_wr_en_o;
   logic [31:0] tag_wr_addr_o;
   logic        clear_all_o;
   logic        clear_line_o;
   logic [31:0] clear_addr_o;
   logic        tag_hit_i;
   logic        lk_rsp_valid_o;
   logic        lk_rsp_hit_o;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int n_cmp  = 0;
   int n_fail = 0;

   dcache_tag_ctrl #(.AWT(32), .WORD_SEL(4), .ENTRY_SEL(7)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lk_valid_i     (lk_valid_i),
      .lk_addr_i      (lk_addr_i),
      .lk_ready_o     (lk_ready_o),
      .rf_valid_i     (rf_valid_i),
      .rf_addr_i      (rf_addr_i),
      .rf_ready_o     (rf_ready_o),
      .csr_req_i      (csr_req_i),
      .csr_all_i      (csr_all_i),
      .csr_addr_i     (csr_addr_i),
      .csr_ack_o      (csr_ack_o),
      .tag_rd_en_o    (tag_rd_en_o),
      .tag_rd_addr_o  (tag_rd_addr_o),
      .tag_wr_en_o    (tag_wr_en_o),
      .tag_wr_addr_o  (tag_wr_addr_o),
      .clear_all_o    (clear_all_o),
      .clear_line_o   (clear_line_o),
      .clear_addr_o   (clear_addr_o),
      .tag_hit_i      (tag_hit_i),
      .lk_rsp_valid_o (lk_rsp_valid_o),
      .lk_rsp_hit_o   (lk_rsp_hit_o),
      .hit_cnt_o      (hit_cnt_o),
      .miss_cnt_o     (miss_cnt_o)
   );

   // 10ns clock.
   always #5 clk_i = ~clk_i;

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cyc();
      cyc();
      rst_i = 1'b0;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", lk_rsp_valid_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_hit: got %b want 0", lk_rsp_hit_o); end
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (clear_all_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_clear_all: got %b want 0", clear_all_o); end
      n_cmp++; if (clear_line_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_clear_line: got %b want 0", clear_line_o); end
      n_cmp++; if (hit_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_hit_cnt: got %h want 0", hit_cnt_o); end
      n_cmp++; if (miss_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_miss_cnt: got %h want 0", miss_cnt_o); end
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_lk_ready: got %b want 1", lk_ready_o); end
      n_cmp++; if (rf_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_rf_ready: got %b want 1", rf_ready_o); end
   endtask

   task automatic test_back_to_back();
      cyc();
      lk_valid_i = 1'b1; lk_addr_i = 32'h1000;
      #1;
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready0: got %b want 1", lk_ready_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rd_en0: got %b want 1", tag_rd_en_o); end
      n_cmp++; if (tag_rd_addr_o !== 32'h1000) begin n_fail++; $display("[TB] FAIL b2b_rd_addr0: got %h want 00001000", tag_rd_addr_o); end
      n_cmp++; if (lk_rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_rsp0: got %b want 0", lk_rsp_valid_o); end
      cyc();
      tag_hit_i = 1'b1;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp1: got %b want 1", lk_rsp_valid_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hit1: got %b want 1", lk_rsp_hit_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rd_en1: got %b want 1", tag_rd_en_o); end
      cyc();
      tag_hit_i = 1'b0;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp2: got %b want 1", lk_rsp_valid_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_hit2: got %b want 0", lk_rsp_hit_o); end
      cyc();
      lk_valid_i = 1'b0; tag_hit_i = 1'b1;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp3: got %b want 1", lk_rsp_valid_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hit3: got %b want 1", lk_rsp_hit_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_rd_en3: got %b want 0", tag_rd_en_o); end
      cyc();
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_rsp4: got %b want 0", lk_rsp_valid_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_hit_masked: got %b want 0", lk_rsp_hit_o); end
      n_cmp++; if (hit_cnt_o !== 32'd2) begin n_fail++; $display("[TB] FAIL b2b_hit_cnt: got %0d want 2", hit_cnt_o); end
      n_cmp++; if (miss_cnt_o !== 32'd1) begin n_fail++; $display("[TB] FAIL b2b_miss_cnt: got %0d want 1", miss_cnt_o); end
      tag_hit_i = 1'b0;
   endtask

   task automatic test_refill_conflict();
      cyc();
      rf_valid_i = 1'b1; rf_addr_i = 32'h2040;
      lk_valid_i = 1'b1; lk_addr_i = 32'h2040;
      #1;
      n_cmp++; if (tag_wr_en_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_wr_en: got %b want 1", tag_wr_en_o); end
      n_cmp++; if (tag_wr_addr_o !== 32'h2040) begin n_fail++; $display("[TB] FAIL rf_wr_addr: got %h want 00002040", tag_wr_addr_o); end
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rf_same_lk_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rf_same_rd_en: got %b want 0", tag_rd_en_o); end
      cyc();
      rf_valid_i = 1'b0;
      #1;
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_retry_ready: got %b want 1", lk_ready_o); end
      n_cmp++; if (tag_rd_addr_o !== 32'h2040) begin n_fail++; $display("[TB] FAIL rf_retry_rd_addr: got %h want 00002040", tag_rd_addr_o); end
      n_cmp++; if (tag_wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rf_idle_wr_en: got %b want 0", tag_wr_en_o); end
      cyc();
      rf_valid_i = 1'b1; rf_addr_i = 32'h2040;
      lk_valid_i = 1'b1; lk_addr_i = 32'h2080;
      tag_hit_i  = 1'b0;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_retry_rsp: got %b want 1", lk_rsp_valid_o); end
      n_cmp++; if (tag_wr_en_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_diff_wr_en: got %b want 1", tag_wr_en_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_diff_rd_en: got %b want 1", tag_rd_en_o); end
      cyc();
      lk_addr_i = 32'h4040;
      tag_hit_i = 1'b1;
      #1;
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rf_alias_lk_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (lk_rsp_hit_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rf_diff_rsp_hit: got %b want 1", lk_rsp_hit_o); end
      cyc();
      rf_valid_i = 1'b0; lk_valid_i = 1'b0; tag_hit_i = 1'b0;
      #1;
      n_cmp++; if (lk_rsp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rf_alias_rsp: got %b want 0", lk_rsp_valid_o); end
      n_cmp++; if (hit_cnt_o !== 32'd3) begin n_fail++; $display("[TB] FAIL rf_hit_cnt: got %0d want 3", hit_cnt_o); end
      n_cmp++; if (miss_cnt_o !== 32'd2) begin n_fail++; $display("[TB] FAIL rf_miss_cnt: got %0d want 2", miss_cnt_o); end
   endtask

   task automatic test_csr_line();
      cyc();
      lk_valid_i = 1'b1; lk_addr_i = 32'h1000;
      #1;
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_pre_ready: got %b want 1", lk_ready_o); end
      cyc();
      csr_req_i = 1'b1; csr_all_i = 1'b0; csr_addr_i = 32'h3000;
      tag_hit_i = 1'b0;
      #1;
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_idle_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (tag_rd_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_idle_rd_en: got %b want 0", tag_rd_en_o); end
      n_cmp++; if (lk_rsp_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_idle_rsp: got %b want 1", lk_rsp_valid_o); end
      cyc();
      #1;
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_drain_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (clear_line_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_drain_clear: got %b want 0", clear_line_o); end
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_drain_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (rf_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_drain_rf_ready: got %b want 1", rf_ready_o); end
      cyc();
      #1;
      n_cmp++; if (clear_line_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_clear_line: got %b want 1", clear_line_o); end
      n_cmp++; if (clear_all_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_clear_all: got %b want 0", clear_all_o); end
      n_cmp++; if (clear_addr_o !== 32'h3000) begin n_fail++; $display("[TB] FAIL line_clear_addr: got %h want 00003000", clear_addr_o); end
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_clear_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (rf_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_clear_rf_ready: got %b want 0", rf_ready_o); end
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_clear_ack: got %b want 0", csr_ack_o); end
      cyc();
      #1;
      n_cmp++; if (csr_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_done_ack: got %b want 1", csr_ack_o); end
      n_cmp++; if (clear_line_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_done_clear: got %b want 0", clear_line_o); end
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_done_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (miss_cnt_o !== 32'd3) begin n_fail++; $display("[TB] FAIL line_miss_cnt: got %0d want 3", miss_cnt_o); end
      csr_req_i = 1'b0;
      cyc();
      lk_valid_i = 1'b0;
      #1;
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL line_post_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL line_post_ready: got %b want 1", lk_ready_o); end
   endtask

   task automatic test_clear_all();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      // 12 lookups; responses land in cycles 1..12, the first 5 hit.
      for (int i = 0; i <= 12; i++) begin
         cyc();
         lk_valid_i = (i < 12);
         lk_addr_i  = 32'h1000 + 32'(i) * 32'h40;
         tag_hit_i  = (i >= 1) && (i <= 5);
      end
      cyc();
      lk_valid_i = 1'b0; tag_hit_i = 1'b0;
      #1;
      n_cmp++; if (hit_cnt_o !== 32'd5) begin n_fail++; $display("[TB] FAIL all_pre_hit: got %0d want 5", hit_cnt_o); end
      n_cmp++; if (miss_cnt_o !== 32'd7) begin n_fail++; $display("[TB] FAIL all_pre_miss: got %0d want 7", miss_cnt_o); end
      cyc();
      csr_req_i = 1'b1; csr_all_i = 1'b1; csr_addr_i = 32'h0;
      cyc();
      cyc();
      #1;
      n_cmp++; if (clear_all_o !== 1'b1) begin n_fail++; $display("[TB] FAIL all_clear_all: got %b want 1", clear_all_o); end
      n_cmp++; if (clear_line_o !== 1'b0) begin n_fail++; $display("[TB] FAIL all_clear_line: got %b want 0", clear_line_o); end
      n_cmp++; if (hit_cnt_o !== 32'd5) begin n_fail++; $display("[TB] FAIL all_clear_hit: got %0d want 5", hit_cnt_o); end
      cyc();
      #1;
      n_cmp++; if (hit_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL all_done_hit: got %0d want 0", hit_cnt_o); end
      n_cmp++; if (miss_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL all_done_miss: got %0d want 0", miss_cnt_o); end
      n_cmp++; if (csr_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL all_done_ack: got %b want 1", csr_ack_o); end
      n_cmp++; if (clear_all_o !== 1'b0) begin n_fail++; $display("[TB] FAIL all_done_clear: got %b want 0", clear_all_o); end
      csr_req_i = 1'b0;
      cyc();
   endtask

   task automatic test_saturate();
      cyc();
      dut.miss_cnt_q = 32'hFFFF_FFFE;
      lk_valid_i = 1'b1; lk_addr_i = 32'h1000; tag_hit_i = 1'b0;
      cyc();
      cyc();
      #1;
      n_cmp++; if (miss_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL sat_first: got %h want ffffffff", miss_cnt_o); end
      cyc();
      lk_valid_i = 1'b0;
      #1;
      n_cmp++; if (miss_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL sat_second: got %h want ffffffff", miss_cnt_o); end
      cyc();
      #1;
      n_cmp++; if (miss_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL sat_hold: got %h want ffffffff", miss_cnt_o); end
      n_cmp++; if (hit_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL sat_hit: got %0d want 0", hit_cnt_o); end
   endtask

   task automatic test_reset_mid();
      cyc();
      csr_req_i = 1'b1; csr_all_i = 1'b1; csr_addr_i = 32'h0;
      cyc();
      cyc();
      #1;
      n_cmp++; if (clear_all_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_clear_before: got %b want 1", clear_all_o); end
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      #1;
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (clear_all_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_clear: got %b want 0", clear_all_o); end
      n_cmp++; if (lk_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_ready: got %b want 0", lk_ready_o); end
      n_cmp++; if (miss_cnt_o !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_rst_miss: got %h want 0", miss_cnt_o); end
      cyc();
      #1;
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_drain_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (clear_all_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_drain_clear: got %b want 0", clear_all_o); end
      cyc();
      #1;
      n_cmp++; if (clear_all_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_again_clear: got %b want 1", clear_all_o); end
      cyc();
      #1;
      n_cmp++; if (csr_ack_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_again_ack: got %b want 1", csr_ack_o); end
      csr_req_i = 1'b0;
      cyc();
      #1;
      n_cmp++; if (csr_ack_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_post_ack: got %b want 0", csr_ack_o); end
      n_cmp++; if (lk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_post_ready: got %b want 1", lk_ready_o); end
   endtask

   // Directed scenario sequence.
   initial begin
      rst_i      = 1'b1;
      lk_valid_i = 1'b0;
      lk_addr_i  = 32'h0;
      rf_valid_i = 1'b0;
      rf_addr_i  = 32'h0;
      csr_req_i  = 1'b0;
      csr_all_i  = 1'b0;
      csr_addr_i = 32'h0;
      tag_hit_i  = 1'b0;
      test_reset();
      test_back_to_back();
      test_refill_conflict();
      test_csr_line();
      test_clear_all();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
